// File: rtl/axi_hdr_pkg.sv
// Shared types and keep-mask helpers for the queued AXI-Stream header inserter.
// Functions work on a fixed-width keep vector; callers zero-extend or truncate to their beat width.
package axi_hdr_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} hdr_state_e;

  localparam int MAX_BYTES = 64;

  function automatic int keep_popcount(input logic [MAX_BYTES-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) n += int'(keep[i]);
    return n;
  endfunction

  // Ones in the top cnt positions of an nbytes-wide keep field.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int nbytes, input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < nbytes && i >= nbytes - cnt) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axi_hdr_fifo.sv
// Header queue: synchronous FIFO, combinational read of the head entry, one-cycle push-to-pop latency.
// A push while full is dropped (push_rdy must be honoured by the source), even if a pop happens that cycle.
module axi_hdr_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axi_stream_insert_header_q.sv
// Prepends a queued 0..DATA_BYTE_WD byte header to each packet; registered output, one cycle in-to-out.
// Input stalls while the output register is full and blocked, while no header is queued, and during flush beats.
module axi_stream_insert_header_q
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1),
  parameter int HDR_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic [DATA_WD-1:0]             data_in,
  input  logic [DATA_BYTE_WD-1:0]        keep_in,
  input  logic                           last_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [DATA_WD-1:0]             data_out,
  output logic [DATA_BYTE_WD-1:0]        keep_out,
  output logic                           last_out,
  input  logic                           valid_insert,
  output logic                           ready_insert,
  input  logic [DATA_WD-1:0]             data_insert,
  input  logic [BYTE_CNT_WD-1:0]         byte_insert_cnt,
  output logic [$clog2(HDR_DEPTH+1)-1:0] hdr_level
);

  hdr_state_e                        state, state_nxt;
  logic [DATA_WD-1:0]                carry;
  logic [BYTE_CNT_WD-1:0]            c_cnt, flush_cnt, flush_cnt_nxt;
  logic [DATA_WD+BYTE_CNT_WD-1:0]    fifo_dat;
  logic                              fifo_pop, fifo_full, fifo_empty;
  logic                              out_adv, beat_acc;
  logic                              load_vld, load_last;
  logic [DATA_WD-1:0]                load_dat;
  logic [DATA_BYTE_WD-1:0]           load_keep;
  int                                total, sh;

  axi_hdr_fifo #(
    .WIDTH (DATA_WD + BYTE_CNT_WD),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (valid_insert),
    .push_dat ({data_insert, byte_insert_cnt}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (hdr_level)
  );

  assign ready_insert = !fifo_full;
  assign out_adv      = !valid_out || ready_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ready_in      = 1'b0;
    fifo_pop      = 1'b0;
    beat_acc      = 1'b0;
    load_vld      = 1'b0;
    load_dat      = '0;
    load_keep     = '0;
    load_last     = 1'b0;
    flush_cnt_nxt = flush_cnt;
    total         = int'(c_cnt) + keep_popcount(MAX_BYTES'(keep_in));
    // Left shift that drops the unused upper bytes of carry so c carry bytes lead the beat.
    sh            = 8 * (DATA_BYTE_WD - int'(c_cnt));
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        ready_in = out_adv;
        if (valid_in && out_adv) begin
          beat_acc  = 1'b1;
          load_vld  = 1'b1;
          load_dat  = DATA_WD'(({carry, data_in} << sh) >> DATA_WD);
          load_keep = '1;
          if (last_in) begin
            if (total <= DATA_BYTE_WD) begin
              load_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, total));
              load_last = 1'b1;
              state_nxt = IDLE;
            end else begin
              flush_cnt_nxt = BYTE_CNT_WD'(total - DATA_BYTE_WD);
              state_nxt     = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_adv) begin
          load_vld  = 1'b1;
          load_dat  = carry << sh;
          load_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, int'(flush_cnt)));
          load_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry     <= '0;
      c_cnt     <= '0;
      flush_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt_nxt;
      if (fifo_pop) begin
        carry <= fifo_dat[DATA_WD+BYTE_CNT_WD-1 -: DATA_WD];
        c_cnt <= fifo_dat[BYTE_CNT_WD-1:0];
      end else if (beat_acc) begin
        carry <= data_in;
      end
      if (out_adv) begin
        valid_out <= load_vld;
        if (load_vld) begin
          data_out <= load_dat;
          keep_out <= load_keep;
          last_out <= load_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header_q.sv
// Scoreboard bench: expected beats come from a byte-stream model (header bytes then payload, chunked per beat).
module tb_axi_stream_insert_header_q;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 3;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, ready_in, last_in;
  logic [DW-1:0] data_in;
  logic [NB-1:0] keep_in;
  logic          valid_out, ready_out, last_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          valid_insert, ready_insert;
  logic [DW-1:0] data_insert;
  logic [CW-1:0] byte_insert_cnt;
  logic [LW-1:0] hdr_level;

  always #5 clk = ~clk;

  axi_stream_insert_header_q dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .valid_out       (valid_out),
    .ready_out       (ready_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .valid_insert    (valid_insert),
    .ready_insert    (ready_insert),
    .data_insert     (data_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .hdr_level       (hdr_level)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct packed { logic [2:0] cnt; logic [31:0] hdr; } hdr_t;

  beat_t exp_q[$];
  hdr_t  hq[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (k[j]) m[8*j +: 8] = 8'hff;
    return m;
  endfunction

  // Output stream = header's low cnt bytes (most significant first) followed by payload, packed MSB-first.
  function automatic void model_pkt(input hdr_t h, input byte unsigned pay[$]);
    byte unsigned s[$];
    beat_t b;
    for (int i = int'(h.cnt) - 1; i >= 0; i--) s.push_back(h.hdr[8*i +: 8]);
    foreach (pay[i]) s.push_back(pay[i]);
    while (s.size() > 0) begin
      b = '0;
      for (int j = 0; j < 4; j++)
        if (s.size() > 0) begin
          b.d[31-8*j -: 8] = s.pop_front();
          b.k[3-j] = 1'b1;
        end
      b.l = (s.size() == 0);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endfunction

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = ($urandom_range(0, 3) != 0);
        default: ready_out = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per output handshake and checks held beats stay stable.
  initial begin
    bit    hold;
    beat_t prev, e;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", valid_out, 1);
          chk("hold_beat", {data_out, keep_out, last_out}, prev);
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h keep %b with none expected", data_out, keep_out);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", data_out & kmask(keep_out), e.d);
            chk("out_keep", keep_out, e.k);
            chk("out_last", last_out, e.l);
          end
        end
        hold   = valid_out && !ready_out;
        prev.d = data_out;
        prev.k = keep_out;
        prev.l = last_out;
      end
    end
  end

  task automatic push_hdr(input logic [2:0] cnt, input logic [31:0] dat);
    int t;
    bit acc;
    hdr_t h;
    t = 0; acc = 1'b0;
    valid_insert = 1'b1; byte_insert_cnt = cnt; data_insert = dat;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = ready_insert;
      tick();
      t++;
    end
    valid_insert = 1'b0;
    if (acc) begin
      h.cnt = cnt; h.hdr = dat;
      hq.push_back(h);
    end else timeout("push_hdr");
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output bit ok);
    int t;
    t = 0; ok = 1'b0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    while (!ok && t < 1000) begin
      @(negedge clk);
      ok = ready_in;
      tick();
      t++;
    end
    valid_in = 1'b0;
    if (!ok) timeout("send_beat");
  endtask

  task automatic send_pkt(input byte unsigned pay[$], input bit gaps, input bit use_model);
    int t, nb, idx;
    bit ok;
    hdr_t h;
    logic [31:0] d;
    logic [3:0]  k;
    t = 0;
    while (hq.size() == 0 && t < 1000) begin tick(); t++; end
    if (hq.size() == 0) begin timeout("hdr_wait"); return; end
    h = hq.pop_front();
    if (use_model) model_pkt(h, pay);
    nb = (pay.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d = '0; k = '0;
      for (int j = 0; j < 4; j++) begin
        idx = b * 4 + j;
        if (idx < pay.size()) begin
          d[31-8*j -: 8] = pay[idx];
          k[3-j] = 1'b1;
        end
      end
      send_beat(d, k, b == nb - 1, ok);
      if (!ok) return;
      if (b == 0) chk("latency", valid_out, 1);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin tick(); t++; end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_valid_out"}, valid_out, 0);
    chk({nm, "_last_out"}, last_out, 0);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_keep_out"}, keep_out, 0);
    chk({nm, "_ready_in"}, ready_in, 0);
    chk({nm, "_ready_insert"}, ready_insert, 1);
    chk({nm, "_hdr_level"}, hdr_level, 0);
  endtask

  task automatic rand_pay(input int n, output byte unsigned p[$]);
    p = {};
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
  endtask

  task automatic case_cnt2();
    byte unsigned p[$];
    push_hdr(3'd2, 32'hAABBCCDD);
    exp_beat(32'hCCDD1122, 4'hf, 1'b0);
    exp_beat(32'h33445566, 4'hf, 1'b0);
    exp_beat(32'h77880000, 4'b1100, 1'b1);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(p, 1'b0, 1'b0);
    drain("drain_cnt2");
  endtask

  initial begin
    byte unsigned p[$];
    bit ok;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; byte_insert_cnt = '0;
    tick();
    check_reset("rst0");
    rst = 1'b0;

    case_cnt2();

    push_hdr(3'd1, 32'h000000DD);
    exp_beat(32'hDD112233, 4'hf, 1'b0);
    exp_beat(32'h44556677, 4'hf, 1'b1);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_pkt(p, 1'b0, 1'b0);
    drain("drain_cnt1");

    push_hdr(3'd0, $urandom);
    rand_pay(12, p);
    send_pkt(p, 1'b0, 1'b1);
    drain("drain_cnt0");

    push_hdr(3'd4, 32'hCAFEF00D);
    exp_beat(32'hCAFEF00D, 4'hf, 1'b0);
    exp_beat(32'h11223344, 4'hf, 1'b0);
    exp_beat(32'h55667788, 4'hf, 1'b1);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(p, 1'b0, 1'b0);
    drain("drain_cnt4");

    // Output stall of three cycles in the middle of a packet.
    push_hdr(3'd2, $urandom);
    rand_pay(16, p);
    fork
      send_pkt(p, 1'b0, 1'b1);
      begin
        repeat (3) tick();
        rdy_mode = 2;
        repeat (3) tick();
        rdy_mode = 0;
      end
    join
    drain("drain_stall");

    // Back-to-back pushes: the first is taken by the FSM, the next four fill the queue.
    for (int i = 0; i < 5; i++) push_hdr(3'($urandom_range(0, 4)), $urandom);
    chk("full_level", hdr_level, 4);
    chk("full_ready_insert", ready_insert, 0);
    valid_insert = 1'b1; byte_insert_cnt = 3'd3; data_insert = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("full_reject", ready_insert, 0);
      tick();
    end
    valid_insert = 1'b0;
    chk("full_level_hold", hdr_level, 4);
    for (int i = 0; i < 5; i++) begin
      rand_pay($urandom_range(1, 10), p);
      send_pkt(p, 1'b0, 1'b1);
    end
    drain("drain_fifo_order");

    // Reset in the middle of a packet with one header still queued.
    push_hdr(3'd2, 32'hAABBCCDD);
    exp_beat(32'hCCDD1122, 4'hf, 1'b0);
    exp_beat(32'h33445566, 4'hf, 1'b0);
    send_beat(32'h11223344, 4'hf, 1'b0, ok);
    send_beat(32'h55667788, 4'hf, 1'b0, ok);
    push_hdr(3'd3, $urandom);
    drain("drain_pre_reset");
    chk("pre_reset_level", hdr_level, 1);
    rst = 1'b1;
    tick();
    check_reset("rst_mid");
    rst = 1'b0;
    exp_q.delete();
    hq.delete();
    case_cnt2();

    // Randomized headers and packets, pushed and sent concurrently under random backpressure.
    rdy_mode = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_hdr(3'($urandom_range(0, 4)), $urandom);
        end
      end
      begin
        byte unsigned rp[$];
        for (int i = 0; i < 40; i++) begin
          rand_pay($urandom_range(1, 20), rp);
          send_pkt(rp, 1'b1, 1'b1);
        end
      end
    join
    rdy_mode = 0;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
